// File: rtl/mem_wb_stage_if.sv
// EX <-> MEM/WB bundle: EX-stage control and operands in, forwarding selects,
// the load-use stall and the register-file write port out.
interface mem_wb_stage_if;
    logic [2:0] ex_rd;
    logic       ex_reg_write;
    logic       ex_mem_read;
    logic       ex_mem_write;
    logic [7:0] ex_store_data;
    logic [2:0] ex_rs1;
    logic [2:0] ex_rs2;
    logic       ex_rs2_used;
    logic       ex_flush;
    logic [7:0] mem_alu_result;
    logic [1:0] forward_a;
    logic [1:0] forward_b;
    logic [7:0] alu_result_mem;
    logic [7:0] write_data_wb;
    logic [2:0] wb_rd;
    logic       wb_reg_write;
    logic       load_use_stall;

    modport master (
        output ex_rd, ex_reg_write, ex_mem_read, ex_mem_write, ex_store_data,
               ex_rs1, ex_rs2, ex_rs2_used, ex_flush, mem_alu_result,
        input  forward_a, forward_b, alu_result_mem, write_data_wb,
               wb_rd, wb_reg_write, load_use_stall
    );

    modport slave (
        input  ex_rd, ex_reg_write, ex_mem_read, ex_mem_write, ex_store_data,
               ex_rs1, ex_rs2, ex_rs2_used, ex_flush, mem_alu_result,
        output forward_a, forward_b, alu_result_mem, write_data_wb,
               wb_rd, wb_reg_write, load_use_stall
    );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage: data RAM, MEM/WB latches, forwarding and load-use stall.
// Define MEMWB_FORWARD_EN for operand forwarding; otherwise every RAW hazard stalls.
module mem_wb_stage #(
    parameter int unsigned ADDR_W = 5
) (
    input  logic         clk,
    input  logic         reset,
    mem_wb_stage_if.slave bus
);
    logic [2:0] mem_rd_q, mem_rd_d;
    logic       mem_reg_write_q, mem_reg_write_d;
    logic       mem_mem_read_q, mem_mem_read_d;
    logic       mem_mem_write_q, mem_mem_write_d;
    logic [7:0] mem_store_data_q, mem_store_data_d;
    logic [2:0] wb_rd_q, wb_rd_d;
    logic       wb_reg_write_q, wb_reg_write_d;
    logic       wb_is_load_q, wb_is_load_d;
    logic [7:0] wb_alu_q, wb_alu_d;
    logic [7:0] ram_rdata_q;
    logic [7:0] ram [0:(1 << ADDR_W) - 1];

    logic              stall;
    logic              bubble;
    logic [ADDR_W-1:0] addr;
    logic              mem_hit_rs1, mem_hit_rs2, wb_hit_rs1, wb_hit_rs2;

    assign addr = bus.mem_alu_result[ADDR_W-1:0];

    // rd = 0 is the hardwired zero register and never counts as a hazard
    always_comb begin
        mem_hit_rs1 = (mem_rd_q != 3'd0) && (mem_rd_q == bus.ex_rs1);
        mem_hit_rs2 = (mem_rd_q != 3'd0) && (mem_rd_q == bus.ex_rs2) && bus.ex_rs2_used;
        wb_hit_rs1  = (wb_rd_q != 3'd0) && (wb_rd_q == bus.ex_rs1);
        wb_hit_rs2  = (wb_rd_q != 3'd0) && (wb_rd_q == bus.ex_rs2) && bus.ex_rs2_used;
    end

    always_comb begin
        bus.forward_a = 2'b00;
        bus.forward_b = 2'b00;
`ifdef MEMWB_FORWARD_EN
        if (mem_reg_write_q && !mem_mem_read_q && mem_hit_rs1)
            bus.forward_a = 2'b10;
        else if (wb_reg_write_q && wb_hit_rs1)
            bus.forward_a = 2'b01;
        if (mem_reg_write_q && !mem_mem_read_q && mem_hit_rs2)
            bus.forward_b = 2'b10;
        else if (wb_reg_write_q && wb_hit_rs2)
            bus.forward_b = 2'b01;
        stall = mem_mem_read_q && mem_reg_write_q && (mem_hit_rs1 || mem_hit_rs2);
`else
        stall = (mem_reg_write_q && (mem_hit_rs1 || mem_hit_rs2)) ||
                (wb_reg_write_q && (wb_hit_rs1 || wb_hit_rs2));
`endif
    end

    assign bubble = bus.ex_flush || stall;

    always_comb begin
        mem_rd_d         = bus.ex_rd;
        mem_store_data_d = bus.ex_store_data;
        mem_reg_write_d  = bus.ex_reg_write && !bubble;
        mem_mem_read_d   = bus.ex_mem_read && !bubble;
        mem_mem_write_d  = bus.ex_mem_write && !bubble;
        wb_rd_d          = mem_rd_q;
        wb_reg_write_d   = mem_reg_write_q;
        wb_is_load_d     = mem_mem_read_q;
        wb_alu_d         = bus.mem_alu_result;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_rd_q         <= '0;
            mem_reg_write_q  <= 1'b0;
            mem_mem_read_q   <= 1'b0;
            mem_mem_write_q  <= 1'b0;
            mem_store_data_q <= '0;
            wb_rd_q          <= '0;
            wb_reg_write_q   <= 1'b0;
            wb_is_load_q     <= 1'b0;
            wb_alu_q         <= '0;
        end else begin
            mem_rd_q         <= mem_rd_d;
            mem_reg_write_q  <= mem_reg_write_d;
            mem_mem_read_q   <= mem_mem_read_d;
            mem_mem_write_q  <= mem_mem_write_d;
            mem_store_data_q <= mem_store_data_d;
            wb_rd_q          <= wb_rd_d;
            wb_reg_write_q   <= wb_reg_write_d;
            wb_is_load_q     <= wb_is_load_d;
            wb_alu_q         <= wb_alu_d;
        end
    end

    // Data RAM has no reset; a write wins over a (disallowed) simultaneous read
    always_ff @(posedge clk) begin
        if (mem_mem_write_q)
            ram[addr] <= mem_store_data_q;
        else if (mem_mem_read_q)
            ram_rdata_q <= ram[addr];
    end

    assign bus.alu_result_mem = bus.mem_alu_result;
    assign bus.write_data_wb  = wb_is_load_q ? ram_rdata_q : wb_alu_q;
    assign bus.wb_rd          = wb_rd_q;
    assign bus.wb_reg_write   = wb_reg_write_q;
    assign bus.load_use_stall = stall;
endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage; expectations follow MEMWB_FORWARD_EN if defined.
module tb_mem_wb_stage;
`ifdef MEMWB_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk;
    logic reset;
    int   tests;
    int   fails;

    mem_wb_stage_if bus ();

    mem_wb_stage #(.ADDR_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_ex(input logic [2:0] rd, input logic rw, input logic mr,
                            input logic mw, input logic [7:0] sd, input logic [2:0] rs1,
                            input logic [2:0] rs2, input logic used, input logic flush);
        bus.ex_rd = rd; bus.ex_reg_write = rw; bus.ex_mem_read = mr;
        bus.ex_mem_write = mw; bus.ex_store_data = sd; bus.ex_rs1 = rs1;
        bus.ex_rs2 = rs2; bus.ex_rs2_used = used; bus.ex_flush = flush;
    endtask

    task automatic drain();
        drive_ex(3'd0, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 3'd0, 1'b0, 1'b0);
        bus.mem_alu_result = 8'h00;
        tick();
        tick();
    endtask

    task automatic test_reset();
        tests++; if (bus.wb_reg_write !== 1'b0) begin fails++; $display("FAIL rst_wb_rw got %b want 0", bus.wb_reg_write); end
        tests++; if (bus.wb_rd !== 3'd0) begin fails++; $display("FAIL rst_wb_rd got %0d want 0", bus.wb_rd); end
        tests++; if (bus.forward_a !== 2'b00 || bus.forward_b !== 2'b00) begin fails++; $display("FAIL rst_fwd got %b/%b want 00/00", bus.forward_a, bus.forward_b); end
        tests++; if (bus.load_use_stall !== 1'b0) begin fails++; $display("FAIL rst_stall got %b want 0", bus.load_use_stall); end
        tests++; if (bus.write_data_wb !== 8'h00) begin fails++; $display("FAIL rst_wdata got %h want 00", bus.write_data_wb); end
    endtask

    task automatic test_alu_forward();
        drain();
        drive_ex(3'd3, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 3'd0, 1'b0, 1'b0);
        tick();
        bus.mem_alu_result = 8'h2A;
        drive_ex(3'd0, 1'b0, 1'b0, 1'b0, 8'h00, 3'd3, 3'd0, 1'b0, 1'b0);
        #1;
        tests++; if (bus.forward_a !== (FWD ? 2'b10 : 2'b00)) begin fails++; $display("FAIL alu_fa_mem got %b want %b", bus.forward_a, FWD ? 2'b10 : 2'b00); end
        tests++; if (bus.alu_result_mem !== 8'h2A) begin fails++; $display("FAIL alu_result_mem got %h want 2a", bus.alu_result_mem); end
        tests++; if (bus.load_use_stall !== !FWD) begin fails++; $display("FAIL alu_stall_mem got %b want %b", bus.load_use_stall, !FWD); end
        tick();
        bus.mem_alu_result = 8'h00;
        #1;
        tests++; if (bus.forward_a !== (FWD ? 2'b01 : 2'b00)) begin fails++; $display("FAIL alu_fa_wb got %b want %b", bus.forward_a, FWD ? 2'b01 : 2'b00); end
        tests++; if (bus.write_data_wb !== 8'h2A) begin fails++; $display("FAIL alu_wdata got %h want 2a", bus.write_data_wb); end
        tests++; if (bus.wb_rd !== 3'd3 || bus.wb_reg_write !== 1'b1) begin fails++; $display("FAIL alu_wb_port got rd=%0d we=%b want rd=3 we=1", bus.wb_rd, bus.wb_reg_write); end
        tests++; if (bus.load_use_stall !== !FWD) begin fails++; $display("FAIL alu_stall_wb got %b want %b", bus.load_use_stall, !FWD); end
        tick();
        tests++; if (bus.load_use_stall !== 1'b0) begin fails++; $display("FAIL alu_stall_clear got %b want 0", bus.load_use_stall); end
    endtask

    task automatic test_store_load();
        drain();
        drive_ex(3'd0, 1'b0, 1'b0, 1'b1, 8'h7F, 3'd0, 3'd0, 1'b0, 1'b0);
        tick();
        bus.mem_alu_result = 8'h05;
        drive_ex(3'd2, 1'b1, 1'b1, 1'b0, 8'h00, 3'd0, 3'd0, 1'b0, 1'b0);
        tick();
        bus.mem_alu_result = 8'h05;
        drive_ex(3'd0, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 3'd0, 1'b0, 1'b0);
        tick();
        tests++; if (bus.write_data_wb !== 8'h7F) begin fails++; $display("FAIL load_wdata got %h want 7f", bus.write_data_wb); end
        tests++; if (bus.wb_rd !== 3'd2 || bus.wb_reg_write !== 1'b1) begin fails++; $display("FAIL load_wb_port got rd=%0d we=%b want rd=2 we=1", bus.wb_rd, bus.wb_reg_write); end
    endtask

    task automatic test_load_use();
        drain();
        drive_ex(3'd4, 1'b1, 1'b1, 1'b0, 8'h00, 3'd0, 3'd0, 1'b0, 1'b0);
        tick();
        bus.mem_alu_result = 8'h05;
        drive_ex(3'd6, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 3'd4, 1'b1, 1'b0);
        #1;
        tests++; if (bus.load_use_stall !== 1'b1) begin fails++; $display("FAIL lu_stall got %b want 1", bus.load_use_stall); end
        tests++; if (bus.forward_b !== 2'b00) begin fails++; $display("FAIL lu_fb_mem got %b want 00", bus.forward_b); end
        tick();
        bus.mem_alu_result = 8'h00;
        #1;
        tests++; if (bus.load_use_stall !== !FWD) begin fails++; $display("FAIL lu_stall_next got %b want %b", bus.load_use_stall, !FWD); end
        tests++; if (bus.forward_b !== (FWD ? 2'b01 : 2'b00)) begin fails++; $display("FAIL lu_fb_wb got %b want %b", bus.forward_b, FWD ? 2'b01 : 2'b00); end
        tests++; if (bus.write_data_wb !== 8'h7F) begin fails++; $display("FAIL lu_wdata got %h want 7f", bus.write_data_wb); end
        tick();
        drive_ex(3'd0, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 3'd0, 1'b0, 1'b0);
        #1;
        tests++; if (bus.wb_reg_write !== 1'b0) begin fails++; $display("FAIL lu_bubble_wb got %b want 0", bus.wb_reg_write); end
    endtask

    task automatic test_no_rs2();
        drain();
        drive_ex(3'd4, 1'b1, 1'b1, 1'b0, 8'h00, 3'd0, 3'd0, 1'b0, 1'b0);
        tick();
        bus.mem_alu_result = 8'h05;
        drive_ex(3'd6, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 3'd4, 1'b0, 1'b0);
        #1;
        tests++; if (bus.load_use_stall !== 1'b0) begin fails++; $display("FAIL nors2_stall got %b want 0", bus.load_use_stall); end
        tick();
        tests++; if (bus.forward_b !== 2'b00 || bus.load_use_stall !== 1'b0) begin fails++; $display("FAIL nors2_wb got fb=%b st=%b want fb=00 st=0", bus.forward_b, bus.load_use_stall); end
    endtask

    task automatic test_r0_and_flush();
        drain();
        drive_ex(3'd0, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 3'd0, 1'b0, 1'b0);
        tick();
        bus.mem_alu_result = 8'h55;
        drive_ex(3'd1, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 3'd0, 1'b1, 1'b0);
        #1;
        tests++; if (bus.forward_a !== 2'b00 || bus.forward_b !== 2'b00 || bus.load_use_stall !== 1'b0) begin fails++; $display("FAIL r0_mem got fa=%b fb=%b st=%b want 00/00/0", bus.forward_a, bus.forward_b, bus.load_use_stall); end
        tick();
        drive_ex(3'd0, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 3'd0, 1'b1, 1'b0);
        #1;
        tests++; if (bus.forward_a !== 2'b00 || bus.forward_b !== 2'b00) begin fails++; $display("FAIL r0_wb got fa=%b fb=%b want 00/00", bus.forward_a, bus.forward_b); end
        drain();
        drive_ex(3'd5, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 3'd0, 1'b0, 1'b1);
        tick();
        bus.mem_alu_result = 8'h33;
        drive_ex(3'd0, 1'b0, 1'b0, 1'b0, 8'h00, 3'd5, 3'd0, 1'b0, 1'b0);
        #1;
        tests++; if (bus.forward_a !== 2'b00 || bus.load_use_stall !== 1'b0) begin fails++; $display("FAIL flush_mem got fa=%b st=%b want 00/0", bus.forward_a, bus.load_use_stall); end
        tick();
        tests++; if (bus.wb_reg_write !== 1'b0) begin fails++; $display("FAIL flush_wb_rw got %b want 0", bus.wb_reg_write); end
    endtask

    task automatic test_reset_mid();
        drain();
        drive_ex(3'd1, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 3'd0, 1'b0, 1'b0);
        tick();
        bus.mem_alu_result = 8'h99;
        drive_ex(3'd0, 1'b0, 1'b0, 1'b0, 8'h00, 3'd1, 3'd0, 1'b0, 1'b0);
        tick();
        tests++; if (bus.wb_reg_write !== 1'b1 || bus.write_data_wb !== 8'h99) begin fails++; $display("FAIL mid_pre got we=%b wd=%h want 1/99", bus.wb_reg_write, bus.write_data_wb); end
        #2 reset = 1'b1;
        #1;
        test_reset();
        #3 reset = 1'b0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        clk   = 1'b0;
        reset = 1'b1;
        drive_ex(3'd0, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 3'd0, 1'b0, 1'b0);
        bus.mem_alu_result = 8'h00;
        #1;
        test_reset();
        #12 reset = 1'b0;
        test_alu_forward();
        test_store_load();
        test_load_use();
        test_no_rs2();
        test_r0_and_flush();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
